// File: rtl/window_framer.sv
// Streaming window framer: assembles samples into overlapping windows, starts the
// extractor once per window and stages the next WINDOW_STEP samples while it runs.
module window_framer #(
    parameter int unsigned WINDOW_SIZE = 256,
    parameter int unsigned WINDOW_STEP = 128,
    parameter int unsigned SAMPLE_SIZE = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    in_valid_i,
    input  logic [SAMPLE_SIZE-1:0]                  in_sample_i,
    output logic                                    in_ready_o,
    output logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] samples_o,
    output logic                                    en_o,
    input  logic                                    done_i,
    output logic [15:0]                             win_count_o
);

    localparam int unsigned FillW  = $clog2(WINDOW_SIZE);
    localparam int unsigned StCntW = $clog2(WINDOW_STEP + 1);
    localparam int unsigned WinW   = WINDOW_SIZE * SAMPLE_SIZE;

    typedef enum logic [2:0] {
        StFill,
        StIssue,
        StBusy,
        StCollect,
        StSlide
    } state_e;

    state_e                                  state_q, state_d;
    logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] win_q, win_d;
    logic [WINDOW_STEP-1:0][SAMPLE_SIZE-1:0] stage_q, stage_d;
    logic [FillW-1:0]                        fill_cnt_q, fill_cnt_d;
    logic [StCntW-1:0]                       stage_cnt_q, stage_cnt_d;
    logic [15:0]                             win_count_q, win_count_d;
    logic                                    stage_room;
    logic                                    stage_wr;

    assign stage_room  = (stage_cnt_q < StCntW'(WINDOW_STEP));
    assign samples_o   = win_q;
    assign win_count_o = win_count_q;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        stage_d     = stage_q;
        fill_cnt_d  = fill_cnt_q;
        stage_cnt_d = stage_cnt_q;
        win_count_d = win_count_q;
        in_ready_o  = 1'b0;
        en_o        = 1'b0;
        stage_wr    = 1'b0;

        unique case (state_q)
            StFill: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    for (int i = 0; i < WINDOW_SIZE; i++) begin
                        if (fill_cnt_q == FillW'(i)) begin
                            win_d[i] = in_sample_i;
                        end
                    end
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == FillW'(WINDOW_SIZE - 1)) begin
                        state_d     = StIssue;
                        win_count_d = win_count_q + 16'd1;
                    end
                end
            end
            StIssue: begin
                en_o       = 1'b1;
                in_ready_o = stage_room;
                stage_wr   = in_valid_i && stage_room;
                state_d    = StBusy;
            end
            StBusy: begin
                in_ready_o = stage_room;
                stage_wr   = in_valid_i && stage_room;
                if (done_i) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                in_ready_o = stage_room;
                stage_wr   = in_valid_i && stage_room;
                if (!stage_room) begin
                    state_d = StSlide;
                end
            end
            StSlide: begin
                // Oldest WINDOW_STEP samples fall off index 0; staging fills the top.
                win_d       = WinW'({stage_q, win_q} >> (WINDOW_STEP * SAMPLE_SIZE));
                stage_cnt_d = '0;
                state_d     = StIssue;
                win_count_d = win_count_q + 16'd1;
            end
            default: state_d = StFill;
        endcase

        if (stage_wr) begin
            for (int i = 0; i < WINDOW_STEP; i++) begin
                if (stage_cnt_q == StCntW'(i)) begin
                    stage_d[i] = in_sample_i;
                end
            end
            stage_cnt_d = stage_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFill;
            win_q       <= '0;
            stage_q     <= '0;
            fill_cnt_q  <= '0;
            stage_cnt_q <= '0;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            stage_q     <= stage_d;
            fill_cnt_q  <= fill_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            win_count_q <= win_count_d;
        end
    end

endmodule

// File: tb/tb_window_framer.sv
// Directed bench for window_framer: fill, backpressure, slides, ignored done and mid-busy reset.
module tb_window_framer;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [15:0]           in_sample;
    logic                  in_ready;
    logic [255:0][15:0]    samples;
    logic                  en;
    logic                  done;
    logic [15:0]           win_count;

    int nvec;
    int nerr;
    logic acc;
    int nv;

    window_framer #(
        .WINDOW_SIZE(256),
        .WINDOW_STEP(128),
        .SAMPLE_SIZE(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_sample_i (in_sample),
        .in_ready_o  (in_ready),
        .samples_o   (samples),
        .en_o        (en),
        .done_i      (done),
        .win_count_o (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; acc records whether the coming rising edge accepts.
    task automatic tick(input logic v, input logic [15:0] s, input logic d);
        in_valid = v;
        in_sample = s;
        done = d;
        acc = v && in_ready && !rst;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick(1'b0, 16'd0, 1'b0);
        tick(1'b0, 16'd0, 1'b0);
        rst = 1'b0;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
        nvec++;
        if (en !== 1'b0) begin
            nerr++; $display("FAIL reset en: got %b want 0", en);
        end
        nvec++;
        if (win_count !== 16'd0) begin
            nerr++; $display("FAIL reset win_count: got %0d want 0", win_count);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'd0) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL reset samples: %0d nonzero entries, want 0", bad);
        end
    endtask

    task automatic test_fill();
        int bad;
        int ens;
        ens = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1'b1, 16'(k), 1'b0);
            nvec++;
            if (en !== (k == 255)) begin
                nerr++; $display("FAIL fill en after sample %0d: got %b want %b", k, en, (k == 255));
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'(i)) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL fill contents: %0d wrong entries, samples[1]=%0d want 1", bad, samples[1]);
        end
        nvec++;
        if (win_count !== 16'd1) begin
            nerr++; $display("FAIL fill win_count: got %0d want 1", win_count);
        end
    endtask

    task automatic test_backpressure();
        int nacc;
        int ens;
        int bad;
        nacc = 0;
        ens = 0;
        nv = 256;
        for (int t = 0; t < 400; t++) begin
            tick(1'b1, 16'(nv), 1'b0);
            if (en === 1'b1) ens++;
            if (acc) begin
                nacc++;
                nv++;
                if (nacc == 128) begin
                    nvec++;
                    if (in_ready !== 1'b0) begin
                        nerr++; $display("FAIL bp ready drop: got %b want 0 after 128th stage", in_ready);
                    end
                end
            end
        end
        nvec++;
        if (nacc != 128) begin
            nerr++; $display("FAIL bp accepts: got %0d want 128", nacc);
        end
        nvec++;
        if (ens != 0) begin
            nerr++; $display("FAIL bp extra en: got %0d pulses want 0", ens);
        end
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++; $display("FAIL bp in_ready: got %b want 0", in_ready);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'(i)) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL bp window held: %0d entries changed, want 0", bad);
        end
    endtask

    task automatic test_done_full();
        logic [2:0] seen;
        int bad;
        tick(1'b0, 16'd0, 1'b1);
        seen[0] = en;
        tick(1'b0, 16'd0, 1'b0);
        seen[1] = en;
        tick(1'b0, 16'd0, 1'b0);
        seen[2] = en;
        nvec++;
        if (seen !== 3'b100) begin
            nerr++; $display("FAIL full slide en timing: got %b want 100", seen);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'(i + 128)) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL full slide contents: %0d wrong, samples[200]=%0d want 328",
                             bad, samples[200]);
        end
        nvec++;
        if (win_count !== 16'd2) begin
            nerr++; $display("FAIL full slide win_count: got %0d want 2", win_count);
        end
    endtask

    task automatic test_partial();
        int nacc;
        int bad;
        nacc = 0;
        nv = 384;
        for (int t = 0; t < 40; t++) begin
            tick(1'b1, 16'(nv), 1'b0);
            if (acc) begin nacc++; nv++; end
        end
        nvec++;
        if (nacc != 40) begin
            nerr++; $display("FAIL partial pre-done accepts: got %0d want 40", nacc);
        end
        tick(1'b0, 16'd0, 1'b1);
        for (int j = 0; j < 88; j++) begin
            tick(1'b1, 16'(nv), 1'b0);
            if (acc) nv++;
            nvec++;
            if (en !== 1'b0) begin
                nerr++; $display("FAIL partial early en at stage %0d: got %b want 0", 41 + j, en);
            end
            tick(1'b0, 16'd0, 1'b0);
            nvec++;
            if (en !== 1'b0) begin
                nerr++; $display("FAIL partial early en gap1 %0d: got %b want 0", j, en);
            end
            tick(1'b0, 16'd0, 1'b0);
            nvec++;
            if (en !== (j == 87)) begin
                nerr++; $display("FAIL partial en gap2 %0d: got %b want %b", j, en, (j == 87));
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'(i + 256)) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL partial contents: %0d wrong, samples[0]=%0d want 256",
                             bad, samples[0]);
        end
        nvec++;
        if (win_count !== 16'd3) begin
            nerr++; $display("FAIL partial win_count: got %0d want 3", win_count);
        end
    endtask

    task automatic test_done_ignored();
        int ens;
        int nacc;
        ens = 0;
        nacc = 0;
        // done arrives during ISSUE; if taken, the full stage below would trigger a slide.
        tick(1'b0, 16'd0, 1'b1);
        for (int t = 0; t < 140; t++) begin
            tick(1'b1, 16'(nv), 1'b0);
            if (en === 1'b1) ens++;
            if (acc) begin nacc++; nv++; end
        end
        nvec++;
        if (ens != 0) begin
            nerr++; $display("FAIL issue-done ignored: got %0d en pulses want 0", ens);
        end
        nvec++;
        if (nacc != 128) begin
            nerr++; $display("FAIL issue-done accepts: got %0d want 128", nacc);
        end
        nvec++;
        if (win_count !== 16'd3) begin
            nerr++; $display("FAIL issue-done win_count: got %0d want 3", win_count);
        end
    endtask

    task automatic test_reset_busy();
        int bad;
        int accs;
        rst = 1'b1;
        tick(1'b1, 16'hbeef, 1'b0);
        rst = 1'b0;
        nvec++;
        if ({in_ready, en, win_count} !== {1'b1, 1'b0, 16'd0}) begin
            nerr++; $display("FAIL rst busy outputs: got ready=%b en=%b cnt=%0d want 1 0 0",
                             in_ready, en, win_count);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'd0) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL rst busy samples: %0d nonzero, want 0", bad);
        end
        accs = 0;
        for (int t = 0; t < 300 && accs < 256; t++) begin
            if (t % 64 == 63) begin
                tick(1'b0, 16'd0, 1'b1);
            end else begin
                tick(1'b1, 16'(1000 + accs), (accs == 100));
                if (acc) accs++;
            end
            nvec++;
            if (en !== (accs == 256)) begin
                nerr++; $display("FAIL refill en after %0d accepts: got %b want %b",
                                 accs, en, (accs == 256));
            end
        end
        nvec++;
        if (win_count !== 16'd1) begin
            nerr++; $display("FAIL refill win_count: got %0d want 1", win_count);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (samples[i] !== 16'(1000 + i)) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL refill contents: %0d wrong, samples[5]=%0d want 1005",
                             bad, samples[5]);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        done = 1'b0;
        acc = 1'b0;
        nv = 0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_backpressure();
        test_done_full();
        test_partial();
        test_done_ignored();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/window_framer.md
# window_framer

Streaming front end for one EEG channel that assembles incoming samples into overlapping analysis windows and hands each window to a feature extractor. It sits between the per-channel sample source and the extractor (such as the mean-amplitude extractor) and drives the extractor's `samples`/`en`/`done` interface from the producing side. It also holds each window stable while the extractor runs, and buffers the next `WINDOW_STEP` samples under valid/ready backpressure.

## Interface
- `WINDOW_SIZE`, 256: samples per window. Must be ≥ 3.
- `WINDOW_STEP`, 128: new samples between consecutive windows. Range 1 ≤ `WINDOW_STEP` ≤ `WINDOW_SIZE`.
- `SAMPLE_SIZE`, 16: sample width, two's complement.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: `in_sample` is valid.
- `in_sample`  in  `SAMPLE_SIZE`: input sample.
- `in_ready`  out  1: framer accepts the sample. A sample is accepted when `in_valid && in_ready`.
- `samples`  out  [`WINDOW_SIZE`-1:0][`SAMPLE_SIZE`-1:0]: current window. Index 0 is the oldest sample; index `WINDOW_SIZE`-1 is the newest.
- `en`  out  1: one-cycle start pulse to the extractor.
- `done`  in  1: extractor finished the current window (one-cycle pulse).
- `win_count`  out  16: number of windows issued since reset; wraps modulo 2^16.

## Operation
- Storage:
  - Window register: `WINDOW_SIZE` × `SAMPLE_SIZE`.
  - Staging buffer: `WINDOW_STEP` entries, plus `fill_cnt` and `stage_cnt`.
- States:
  - FILL:
    - `in_ready`=1.
    - Each accepted sample is written to `samples[fill_cnt]`, then `fill_cnt` increments.
    - On the accept that makes `fill_cnt`=`WINDOW_SIZE`, go to ISSUE.
  - ISSUE:
    - `en`=1 for this cycle only, and `win_count` increments.
    - Go to BUSY.
    - `in_ready` = (`stage_cnt` < `WINDOW_STEP`); accepted samples are written to `stage[stage_cnt]`.
  - BUSY:
    - Staging accepts samples as in ISSUE.
    - `samples` must not change.
    - On `done`=1, go to COLLECT.
  - COLLECT:
    - Staging accepts samples as in ISSUE.
    - When `stage_cnt`=`WINDOW_STEP` at the start of the cycle, go to SLIDE.
  - SLIDE:
    - `in_ready`=0.
    - The window shifts toward index 0 by `WINDOW_STEP`: `samples[i]` ← `samples[i+WINDOW_STEP]` for i < `WINDOW_SIZE`-`WINDOW_STEP`, and the upper `WINDOW_STEP` slots ← `stage[0..WINDOW_STEP-1]` in arrival order.
    - `stage_cnt` ← 0; go to ISSUE.
- `done` is ignored in every state except BUSY.
- `en` is never asserted outside ISSUE. `in_valid` without `in_ready` has no effect.
- No arithmetic is performed on samples. Values pass through bit-exact.
- When `WINDOW_STEP`=`WINDOW_SIZE`, the window is replaced entirely by staged data.

## Timing
- Reset values:
  - `in_ready`=1, `en`=0, `win_count`=0.
  - All `samples` = 0, all staging entries = 0.
  - `fill_cnt`=0, `stage_cnt`=0, state=FILL.
- A reset asserted in any state, including mid-BUSY with the extractor running, discards both the window and the staging buffer. The next `en` occurs only after `WINDOW_SIZE` new accepts.
- First window: `en` is high in the cycle immediately after the edge that accepted sample `WINDOW_SIZE`-1 (0-based).
- Steady state with staging already full when `done` is sampled at edge d:
  - COLLECT during cycle d+1.
  - SLIDE during cycle d+2.
  - `en` high during cycle d+3.
- Staging not full at `done`: `en` is high 2 cycles after the edge that accepts the final staged sample (COLLECT → SLIDE → ISSUE).
- `samples` is stable from the `en` cycle through the cycle in which `done` is sampled, inclusive. It changes only on the SLIDE edge or during FILL.
- Continuous input at one sample per cycle, with the extractor busy longer than `WINDOW_STEP` cycles: `in_ready` falls the cycle after the `WINDOW_STEP`-th staged accept and stays 0 through SLIDE.
- `win_count` updates on the same edge that enters ISSUE, so it is visible while `en`=1.

## Test plan
- Reset, then stream samples of value k for k=0..255 at full rate.
  - Required: `en`=1 for exactly one cycle, the cycle after sample 255 is accepted.
  - Required: `samples[i]`=i and `win_count`=1.
- Continue streaming with `done` withheld for 400 cycles.
  - Required: exactly 128 further samples are accepted, then `in_ready`=0.
  - Required: `samples` stays unchanged and no second `en` occurs.
- Pulse `done` with staging full.
  - Required: `en` high exactly 3 cycles after the `done` edge.
  - Required: `samples[i]`=i+128 for all i, and `win_count`=2.
- Pulse `done` after only 40 staged samples, then feed 1 sample every 3 cycles.
  - Required: no `en` until the 128th staged accept; `en` follows 2 cycles later with the correct shifted contents.
- Pulse `done` during FILL and during ISSUE.
  - Required: both are ignored; state and `win_count` are unaffected.
- Assert `rst` for 1 cycle mid-BUSY after 3 windows.
  - Required: all outputs return to their reset values and `in_ready`=1.
  - Required: the next `en` occurs only after 256 fresh accepts, with `win_count`=1.
